// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M execute unit living beside the main ALU.
// Decodes the eight M-extension ops (ALUOp=10, Funct7=0000001), runs an
// iterative shift-add multiply or restoring divide, and holds Stall high
// until the result is ready. Result is valid while Done pulses.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   Start    execute-stage instruction valid
//   ALUOp    controller opcode class
//   Funct7   instruction bits 31:25
//   Funct3   instruction bits 14:12 (selects the M op)
//   SrcA     rs1 operand
//   SrcB     rs2 operand
//   Flush    pipeline flush; aborts any operation in flight
//   IsMulDiv combinational M-extension decode
//   Busy     high while iterating (CALC) or sign fixing (FIX)
//   Stall    holds the pipeline while an M op is pending
//   Done     one-cycle completion pulse
//   Result   registered result, held until the next accepted op
//
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle combinational multiplier (divides stay iterative).

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             IsMulDiv,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic             neg;     // final result must be negated in FIX
    logic [WIDTH-1:0] b_reg;   // divisor / multiplicand magnitude
    logic [WIDTH:0]   rem;     // divide: partial remainder; multiply: high half
    logic [WIDTH-1:0] lo;      // divide: dividend->quotient; multiply: multiplier->low half

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic             is_div_in, is_rem_in, a_signed, b_signed;
    logic             a_neg_in, b_neg_in, b_zero, div_ovf, special, accept;
    logic [WIDTH-1:0] a_mag_in, b_mag_in, special_val;

    assign IsMulDiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign accept   = (state == IDLE) && Start && IsMulDiv && !Flush;
    assign Busy     = (state == CALC) || (state == FIX);
    assign Done     = (state == DONE);
    assign Stall    = (Start && IsMulDiv && (state == IDLE)) || Busy;

    always_comb begin
        is_div_in = Funct3[2];
        is_rem_in = Funct3[2] & Funct3[1];
        a_signed  = (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                    (Funct3 == OP_DIV)  || (Funct3 == OP_REM);
        b_signed  = (Funct3 == OP_MULH) || (Funct3 == OP_DIV) || (Funct3 == OP_REM);
        a_neg_in  = a_signed & SrcA[WIDTH-1];
        b_neg_in  = b_signed & SrcB[WIDTH-1];
        a_mag_in  = a_neg_in ? -SrcA : SrcA;
        b_mag_in  = b_neg_in ? -SrcB : SrcB;
        b_zero    = (SrcB == '0);
        // signed divide overflow: most-negative / -1
        div_ovf   = b_signed && is_div_in && (SrcA == MIN_NEG) && (SrcB == '1);
        special   = is_div_in && (b_zero || div_ovf);
        if (b_zero)
            special_val = is_rem_in ? SrcA : '1;
        else
            special_val = is_rem_in ? '0 : SrcA;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands sign/zero-extended to 2*WIDTH; the low 2*WIDTH bits of the
    // unsigned product are then the correct two's-complement product.
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
    logic [WIDTH-1:0]   fast_val;

    always_comb begin
        fast_a    = {{WIDTH{a_neg_in}}, SrcA};
        fast_b    = {{WIDTH{b_neg_in}}, SrcB};
        fast_prod = fast_a * fast_b;
        fast_val  = (Funct3 == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`endif

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        // shift-add: conditionally add multiplicand into high half, then shift right
        mul_sum   = {1'b0, rem[WIDTH-1:0]} + (lo[0] ? {1'b0, b_reg} : '0);
        // restoring divide: bring in next dividend bit, trial-subtract divisor
        div_shift = {rem, lo[WIDTH-1]};
        div_ge    = (div_shift >= {2'b00, b_reg});
        div_diff  = div_shift[WIDTH:0] - {1'b0, b_reg};
    end

    // ------------------------------------------------------------------
    // Sign correction and output select
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        prod     = {rem[WIDTH-1:0], lo};
        prod_fix = neg ? -prod : prod;
        quo_fix  = neg ? -lo : lo;
        rem_fix  = neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        case (op)
            OP_MUL:                      fix_val = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             fix_val = quo_fix;
            default:                     fix_val = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            neg    <= 1'b0;
            b_reg  <= '0;
            rem    <= '0;
            lo     <= '0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= Funct3;
                        // remainder follows the dividend; products/quotients follow sign mismatch
                        neg   <= is_rem_in ? a_neg_in : (a_neg_in ^ b_neg_in);
                        b_reg <= b_mag_in;
                        lo    <= a_mag_in;
                        rem   <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        if (special) begin
                            Result <= special_val;
                            state  <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div_in) begin
                            Result <= fast_val;
                            state  <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        if (op[2]) begin
                            rem <= div_ge ? div_diff : div_shift[WIDTH:0];
                            lo  <= {lo[WIDTH-2:0], div_ge};
                        end else begin
                            rem <= {1'b0, mul_sum[WIDTH:1]};
                            lo  <= {mul_sum[0], lo[WIDTH-1:1]};
                        end
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - CNT_W'(1);
                    end
                end

                FIX: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        Result <= fix_val;
                        state  <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32): directed M-extension
// vectors, randomized ops against an arithmetic reference model, flush and
// reset aborts, back-to-back issue and non-M decode.

module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
    localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        Flush;
    logic        IsMulDiv, Busy, Stall, Done;
    logic [31:0] Result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUOp(ALUOp), .Funct7(Funct7),
        .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
        .IsMulDiv(IsMulDiv), .Busy(Busy), .Stall(Stall), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    // Arithmetic reference for every M op, including the divide corner cases.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        a_s, b_s, ovf;
        logic [31:0] r;
        a_s = (f3 == 3'd1) || (f3 == 3'd2);
        b_s = (f3 == 3'd1);
        ea  = a_s ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = b_s ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        ovf = (a == MIN_NEG) && (b == ALL1);
        r   = '0;
        case (f3)
            3'd0:             r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4: r = (b == 0) ? ALL1 : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'd5: r = (b == 0) ? ALL1 : a / b;
            3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == ALL1)))
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2])
            return 1;
`endif
        return W + 2;
    endfunction

    // Drive one M op at cycle 0 and watch until Done; hist[c] records Stall in cycle c.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat, output logic [63:0] hist);
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1;
        hist = '0;
        lat  = -1;
        #1;
        hist[0] = Stall;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (!hold) Start = 1'b0;
            #1;
            hist[c] = Stall;
            if (Done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; Flush = 1'b0; ALUOp = 2'b00; Funct7 = '0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        #12;
        n_cmp++; if (Busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_cmp++; if (Done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b expected 0", Done); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", Stall); end
        n_cmp++; if (Result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", Result); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        exp_result = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
        logic [31:0] as  [14] = '{32'd7, ALL1, ALL1, ALL1, -32'd20, -32'd20, 32'd20, 32'd20,
                                  32'h1234, 32'h1234, MIN_NEG, MIN_NEG, 32'h1234, 32'h1234};
        logic [31:0] bs  [14] = '{32'hFFFF_FFFD, ALL1, ALL1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3,
                                  32'd0, 32'd0, ALL1, ALL1, 32'd0, 32'd0};
        logic [31:0] exp [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, ALL1, 32'hFFFF_FFFA,
                                  32'hFFFF_FFFE, 32'd6, 32'd2, ALL1, 32'h1234, MIN_NEG, 32'd0,
                                  32'h1234, ALL1};
        int lat, el;
        logic [63:0] hist;
        for (int i = 0; i < 14; i++) begin
            issue(f3s[i], as[i], bs[i], 1'b0, lat, hist);
            el = exp_lat(f3s[i], as[i], bs[i]);
            n_cmp++;
            if (lat != el) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el); end
            n_cmp++;
            if (Result !== exp[i]) begin n_bad++; $display("FAIL dir%0d_result: got %h expected %h", i, Result, exp[i]); end
            n_cmp++;
            if (hist !== ((64'd1 << el) - 64'd1))
                begin n_bad++; $display("FAIL dir%0d_stall: got %h expected %h", i, hist, (64'd1 << el) - 64'd1); end
            exp_result = exp[i];
            @(posedge clk); #1;
            n_cmp++;
            if (Done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, Done); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, er;
        int lat, el, sel;
        logic [63:0] hist;
        for (int i = 0; i < 30; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = MIN_NEG; b = ALL1; end
            else if (sel == 2) begin
                a = $urandom_range(0, 200); b = $urandom_range(1, 15);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            issue(f3, a, b, 1'b0, lat, hist);
            el = exp_lat(f3, a, b);
            er = model(f3, a, b);
            n_cmp++;
            if (lat != el) begin n_bad++; $display("FAIL rnd%0d_latency: op %0d got %0d expected %0d", i, f3, lat, el); end
            n_cmp++;
            if (Result !== er)
                begin n_bad++; $display("FAIL rnd%0d_result: op %0d a=%h b=%h got %h expected %h", i, f3, a, b, Result, er); end
            exp_result = er;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        int seen;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd4;
        SrcA = $urandom; SrcB = $urandom_range(2, 1000); Start = 1'b1;
        @(posedge clk); #1; Start = 1'b0;          // cycle 1
        repeat (9) @(posedge clk);
        #1;                                        // cycle 10
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b expected 1", Busy); end
        Flush = 1'b1;
        @(posedge clk); #1; Flush = 1'b0;          // cycle 11
        #1;
        n_cmp++; if (Busy !== 1'b0)  begin n_bad++; $display("FAIL flush_busy_after: got %b expected 0", Busy); end
        n_cmp++; if (Done !== 1'b0)  begin n_bad++; $display("FAIL flush_done: got %b expected 0", Done); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", Stall); end
        n_cmp++; if (Result !== exp_result) begin n_bad++; $display("FAIL flush_result: got %h expected %h", Result, exp_result); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (Done === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd5;
        SrcA = $urandom; SrcB = $urandom_range(1, 50); Start = 1'b1;
        @(posedge clk); #1; Start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", Busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (Busy !== 1'b0)  begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall: got %b expected 0", Stall); end
        n_cmp++; if (Result !== 32'd0) begin n_bad++; $display("FAIL rstmid_result: got %h expected 0", Result); end
        @(negedge clk); reset = 1'b1;
        exp_result = '0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (Done === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int lat, el;
        logic [63:0] hist;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        issue(3'd0, a1, b1, 1'b1, lat, hist);      // Start held through DONE
        el = exp_lat(3'd0, a1, b1);
        n_cmp++; if (lat != el) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, el); end
        n_cmp++; if (Result !== model(3'd0, a1, b1))
            begin n_bad++; $display("FAIL b2b_first_result: got %h expected %h", Result, model(3'd0, a1, b1)); end
        SrcA = a2; SrcB = b2;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_in_done: got %b expected 0", Stall); end
        @(posedge clk); #2;                        // following IDLE cycle
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_idle: got %b expected 1", Stall); end
        n_cmp++; if (Done !== 1'b0)  begin n_bad++; $display("FAIL b2b_done_idle: got %b expected 0", Done); end
        issue(3'd0, a2, b2, 1'b0, lat, hist);
        n_cmp++; if (lat != el) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, el); end
        exp_result = model(3'd0, a2, b2);
        n_cmp++; if (Result !== exp_result)
            begin n_bad++; $display("FAIL b2b_second_result: got %h expected %h", Result, exp_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_non_m();
        int seen;
        ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'($urandom_range(0, 7));
        SrcA = $urandom; SrcB = $urandom; Start = 1'b1;
        #1;
        n_cmp++; if (IsMulDiv !== 1'b0) begin n_bad++; $display("FAIL nonm_decode: got %b expected 0", IsMulDiv); end
        n_cmp++; if (Stall !== 1'b0)    begin n_bad++; $display("FAIL nonm_stall: got %b expected 0", Stall); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (Busy === 1'b1 || Done === 1'b1 || Stall === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL nonm_state: got %0d active cycles expected 0", seen); end
        ALUOp = 2'b00; Funct7 = 7'b0000001;
        #1;
        n_cmp++; if (IsMulDiv !== 1'b0) begin n_bad++; $display("FAIL nonm_aluop: got %b expected 0", IsMulDiv); end
        ALUOp = 2'b10; Start = 1'b0;
        #1;
        n_cmp++; if (IsMulDiv !== 1'b1) begin n_bad++; $display("FAIL m_decode: got %b expected 1", IsMulDiv); end
        n_cmp++; if (Stall !== 1'b0)    begin n_bad++; $display("FAIL m_nostart_stall: got %b expected 0", Stall); end
        n_cmp++; if (Result !== exp_result) begin n_bad++; $display("FAIL nonm_result: got %h expected %h", Result, exp_result); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_non_m();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
